qdrii_reset_sequencer: RTL and testbench

Drives the active-low system reset into the QDRII reset infrastructure and supervises the bring-up that follows. It holds the memory subsystem in reset for a programmed time, then waits for PLL/DCM lock, IDELAYCTRL ready and calibration done. It retries on timeout, restarts on loss of lock in service, and reports ready or fail to the host-side logic. It sits in a free-running clock domain that is independent of the PLL it resets.

---
 rtl/qdrii_reset_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_qdrii_reset_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdrii_reset_sequencer.sv
// Reset sequencer for the QDRII memory subsystem: reset hold, lock/ready/calibration wait, loss recovery.
// Define QDRII_RST_SEQ_TIMEOUT_EN to enforce lock/cal timeouts with bounded retries and a FAIL state.
module qdrii_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 25,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned CAL_TIMEOUT     = 1048575,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_rst_req,
    input  logic       locked,
    input  logic       idelay_ctrl_rdy,
    input  logic       cal_done,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_WAIT_CAL  = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
`ifdef QDRII_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_LAST = 8'(MAX_RETRIES - 1);
`endif

    // Reject parameter sets the timer or retry counter cannot represent
    if (RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT < 2 || CAL_TIMEOUT < 2 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 255 ||
        (64'(RST_HOLD_CYCLES) >> CNT_W) != 64'd0 ||
        (64'(LOCK_TIMEOUT) >> CNT_W) != 64'd0 ||
        (64'(CAL_TIMEOUT) >> CNT_W) != 64'd0) begin : g_cfg_err
        $error("qdrii_reset_sequencer: invalid parameter set");
    end

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_lock_sync;
    logic [1:0]       r_rdy_sync;
    logic [1:0]       r_cal_sync;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic [7:0]       r_loss_count;
    logic             w_up_s;
    logic             w_cal_s;
    logic             w_count;
    logic             w_retry;
    logic             w_loss;

    assign w_up_s  = r_lock_sync[1] & r_rdy_sync[1];
    assign w_cal_s = r_cal_sync[1];

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_sync <= 2'b00;
            r_rdy_sync  <= 2'b00;
            r_cal_sync  <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], locked};
            r_rdy_sync  <= {r_rdy_sync[0], idelay_ctrl_rdy};
            r_cal_sync  <= {r_cal_sync[0], cal_done};
        end
    end

`ifdef QDRII_RST_SEQ_TIMEOUT_EN
    logic [7:0] r_retry_cnt;

    assign w_count = (r_state == ST_RST_HOLD) || (r_state == ST_WAIT_LOCK) ||
                     (r_state == ST_WAIT_CAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry_cnt <= 8'd0;
        end else if (soft_rst_req || (w_next == ST_RUN && r_state != ST_RUN)) begin
            r_retry_cnt <= 8'd0;
        end else if (w_retry) begin
            r_retry_cnt <= r_retry_cnt + 8'd1;
        end
    end
`else
    assign w_count = (r_state == ST_RST_HOLD);
`endif

    // Next-state logic; soft restart outranks success, success outranks timeout/loss
    always_comb begin
        w_next  = r_state;
        w_retry = 1'b0;
        w_loss  = 1'b0;
        if (soft_rst_req) begin
            w_next = ST_RST_HOLD;
        end else begin
            case (r_state)
                ST_RST_HOLD: begin
                    if (r_timer == HOLD_LAST) w_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_up_s) w_next = ST_WAIT_CAL;
`ifdef QDRII_RST_SEQ_TIMEOUT_EN
                    else if (r_timer == LOCK_LAST) w_retry = 1'b1;
`endif
                end
                ST_WAIT_CAL: begin
                    if (!w_up_s) w_retry = 1'b1;
                    else if (w_cal_s) w_next = ST_RUN;
`ifdef QDRII_RST_SEQ_TIMEOUT_EN
                    else if (r_timer == CAL_LAST) w_retry = 1'b1;
`endif
                end
                ST_RUN: begin
                    if (!w_up_s) begin
                        w_next = ST_RST_HOLD;
                        w_loss = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_next = ST_FAIL;
                end
                default: w_next = ST_RST_HOLD;
            endcase
            if (w_retry) begin
`ifdef QDRII_RST_SEQ_TIMEOUT_EN
                w_next = (r_retry_cnt == RETRY_LAST) ? ST_FAIL : ST_RST_HOLD;
`else
                w_next = ST_RST_HOLD;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    // Timer restarts on every state entry, including a soft restart within RST_HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (soft_rst_req || w_next != r_state) begin
            r_timer <= '0;
        end else if (w_count) begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
            r_loss_count <= 8'd0;
        end else begin
            r_sys_rst_n <= (w_next == ST_WAIT_LOCK) || (w_next == ST_WAIT_CAL) ||
                           (w_next == ST_RUN);
            r_ready     <= (w_next == ST_RUN);
            if (w_loss && r_loss_count != 8'hFF) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
        end
    end

`ifdef QDRII_RST_SEQ_TIMEOUT_EN
    logic r_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= (w_next == ST_FAIL);
        end
    end

    assign fail = r_fail;
`else
    assign fail = 1'b0;
`endif

    assign sys_rst_n  = r_sys_rst_n;
    assign ready      = r_ready;
    assign state      = r_state;
    assign loss_count = r_loss_count;

endmodule

// File: tb/tb_qdrii_reset_sequencer.sv
// Bench for qdrii_reset_sequencer: directed bring-up, loss, restart and timeout scenarios checked
// every cycle against a phase/duration model plus literal expectations.
module tb_qdrii_reset_sequencer;

    localparam int RH    = 4;
    localparam int LT    = 16;
    localparam int CT    = 32;
    localparam int MR    = 2;
    localparam int HIST  = 32768;
    localparam int RETRY = 99;
`ifdef QDRII_RST_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_rst_req;
    logic       locked;
    logic       idelay_ctrl_rdy;
    logic       cal_done;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] loss_count;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    qdrii_reset_sequencer #(
        .RST_HOLD_CYCLES(RH),
        .LOCK_TIMEOUT   (LT),
        .CAL_TIMEOUT    (CT),
        .MAX_RETRIES    (MR),
        .CNT_W          (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .soft_rst_req   (soft_rst_req),
        .locked         (locked),
        .idelay_ctrl_rdy(idelay_ctrl_rdy),
        .cal_done       (cal_done),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .fail           (fail),
        .state          (state),
        .loss_count     (loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: phase number, edge of phase entry, and input history for the 2-edge sync delay
    logic [2:0] in_at [HIST];
    int cyc = 0;
    int m_rst_cyc = -100;
    int m_ph = 0;
    int m_entry = 0;
    int m_tries = 0;
    int m_loss = 0;
    logic [2:0] m_s;
    bit m_up;
    int m_dur;
    int m_go;

    always @(posedge clk) begin
        in_at[cyc % HIST] = {cal_done, idelay_ctrl_rdy, locked};
        if (reset) begin
            m_rst_cyc = cyc;
            m_ph = 0;
            m_entry = cyc;
            m_tries = 0;
            m_loss = 0;
        end else begin
            m_s   = (cyc - 2 > m_rst_cyc) ? in_at[(cyc - 2) % HIST] : 3'b000;
            m_up  = m_s[0] & m_s[1];
            m_dur = cyc - m_entry;
            m_go  = -1;
            if (soft_rst_req) begin
                m_go = 0;
                m_tries = 0;
            end else begin
                case (m_ph)
                    0: if (m_dur == RH) m_go = 1;
                    1: begin
                        if (m_up) m_go = 2;
                        else if (TO_EN && m_dur == LT) m_go = RETRY;
                    end
                    2: begin
                        if (!m_up) m_go = RETRY;
                        else if (m_s[2]) m_go = 3;
                        else if (TO_EN && m_dur == CT) m_go = RETRY;
                    end
                    3: if (!m_up) begin
                        m_go = 0;
                        if (m_loss < 255) m_loss++;
                    end
                    default: ;
                endcase
            end
            if (m_go == RETRY) begin
                if (TO_EN) begin
                    m_tries++;
                    m_go = (m_tries == MR) ? 4 : 0;
                end else begin
                    m_go = 0;
                end
            end
            if (m_go == 3) m_tries = 0;
            if (m_go >= 0) begin
                m_ph = m_go;
                m_entry = cyc;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(m_ph));
            check("sys_rst_n", 32'(sys_rst_n), 32'(m_ph >= 1 && m_ph <= 3));
            check("ready", 32'(ready), 32'(m_ph == 3));
            check("fail", 32'(fail), 32'(m_ph == 4));
            check("loss_count", 32'(loss_count), 32'(m_loss));
        end
    end

    task automatic wait_state(input int s, input int lim, input string nm);
        int n = 0;
        while (state !== 3'(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(state), 32'(s));
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nom_st [6] = '{0, 0, 0, 1, 2, 3};
        int nom_rn [6] = '{0, 0, 0, 1, 1, 1};
        int n;

        reset = 1'b1;
        soft_rst_req = 1'b0;
        locked = 1'b1;
        idelay_ctrl_rdy = 1'b1;
        cal_done = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_loss", 32'(loss_count), 32'd0);

        // Nominal bring-up
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nom_state", 32'(state), 32'(nom_st[i]));
            check("nom_rst_n", 32'(sys_rst_n), 32'(nom_rn[i]));
        end
        check("nom_ready", 32'(ready), 32'd1);

        // Single-cycle loss of lock in RUN
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        @(negedge clk);
        check("loss_ready_hold", 32'(ready), 32'd1);
        @(negedge clk);
        check("loss_ready_drop", 32'(ready), 32'd0);
        check("loss_count1", 32'(loss_count), 32'd1);
        n = 0;
        while (sys_rst_n === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("loss_hold_len", 32'(n), 32'd4);
        wait_state(3, 10, "loss_rerun");
        for (int k = 0; k < 299; k++) begin
            locked = 1'b0;
            @(negedge clk);
            locked = 1'b1;
            repeat (2) @(negedge clk);
            wait_state(3, 20, "loss_rep_rerun");
        end
        check("loss_sat", 32'(loss_count), 32'd255);

        // Soft restart coincident with cal_done_s going high
        cal_done = 1'b0;
        pulse_soft();
        wait_state(2, 10, "sc_wait_cal");
        cal_done = 1'b1;
        repeat (2) @(negedge clk);
        check("sc_pre", 32'(state), 32'd2);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        check("sc_state", 32'(state), 32'd0);
        check("sc_rst_n", 32'(sys_rst_n), 32'd0);
        wait_state(3, 10, "sc_rerun");

`ifdef QDRII_RST_SEQ_TIMEOUT_EN
        // cal_done_s first high in the last WAIT_CAL timeout cycle
        cal_done = 1'b0;
        pulse_soft();
        wait_state(2, 10, "bd_wait_cal");
        repeat (29) @(negedge clk);
        cal_done = 1'b1;
        repeat (2) @(negedge clk);
        check("bd_pre", 32'(state), 32'd2);
        @(negedge clk);
        check("bd_run", 32'(state), 32'd3);
        check("bd_ready", 32'(ready), 32'd1);

        // Lock timeout twice, then FAIL
        locked = 1'b0;
        pulse_soft();
        repeat (20) @(negedge clk);
        check("to_retry", 32'(state), 32'd0);
        repeat (19) @(negedge clk);
        check("to_pre", 32'(state), 32'd1);
        @(negedge clk);
        check("to_state", 32'(state), 32'd4);
        check("to_fail", 32'(fail), 32'd1);
        check("to_rst_n", 32'(sys_rst_n), 32'd0);
        repeat (10) @(negedge clk);
        check("to_stay", 32'(state), 32'd4);

        // Recovery from FAIL
        locked = 1'b1;
        pulse_soft();
        check("rec_state", 32'(state), 32'd0);
        check("rec_fail", 32'(fail), 32'd0);
        repeat (6) @(negedge clk);
        check("rec_run", 32'(state), 32'd3);
        check("rec_ready", 32'(ready), 32'd1);
`else
        // Without timeouts WAIT_LOCK waits indefinitely
        locked = 1'b0;
        pulse_soft();
        wait_state(1, 10, "nt_wait_lock");
        repeat (1000) @(negedge clk);
        check("nt_state", 32'(state), 32'd1);
        check("nt_fail", 32'(fail), 32'd0);
        check("nt_rst_n", 32'(sys_rst_n), 32'd1);
        locked = 1'b1;
        repeat (2) @(negedge clk);
        check("nt_pre", 32'(state), 32'd1);
        @(negedge clk);
        check("nt_cal", 32'(state), 32'd2);
        @(negedge clk);
        check("nt_run", 32'(state), 32'd3);
`endif

        // Synchronous reset from RUN clears loss_count
        reset = 1'b1;
        @(negedge clk);
        check("rr_state", 32'(state), 32'd0);
        check("rr_loss", 32'(loss_count), 32'd0);
        check("rr_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        wait_state(3, 20, "rr_rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
